// File: rtl/avl_mm_dot_accel_pkg.sv
// ============================================================================
// Module      : dot_accel_pkg
// Description : Shared constants for the Avalon-MM dot-product accelerator:
//               register map, CTRL/STATUS bit positions, FSM encoding,
//               signed/unsigned arithmetic selection and the LEN clamp helper.
//               Optional feature macro: AVL_DOT_SIGNED_EN (signed elements).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package dot_accel_pkg;

    // Register map
    localparam logic [2:0] c_addr_ctrl   = 3'd0;
    localparam logic [2:0] c_addr_a_push = 3'd1;
    localparam logic [2:0] c_addr_b_push = 3'd2;
    localparam logic [2:0] c_addr_len    = 3'd3;
    localparam logic [2:0] c_addr_result = 3'd4;

    // CTRL write bits
    localparam int c_ctrl_start_bit = 0;
    localparam int c_ctrl_clear_bit = 1;

    // CTRL read (status) bits
    localparam int c_stat_busy_bit = 0;
    localparam int c_stat_done_bit = 1;

    // FSM encoding
    localparam logic [1:0] c_st_idle  = 2'd0;
    localparam logic [1:0] c_st_run   = 2'd1;
    localparam logic [1:0] c_st_drain = 2'd2;
    localparam logic [1:0] c_st_done  = 2'd3;

    // Arithmetic flavour: when set, elements and sums are two's complement
`ifdef AVL_DOT_SIGNED_EN
    localparam bit SIGNED_EN = 1'b1;
`else
    localparam bit SIGNED_EN = 1'b0;
`endif

    // A zero or oversized length falls back to the full buffer depth
    function automatic logic [31:0] clamp_len(input logic [31:0] v, input logic [31:0] depth);
        return ((v == 32'd0) || (v > depth)) ? depth : v;
    endfunction

endpackage

`default_nettype wire

// File: rtl/avl_mm_dot_accel_if.sv
// ============================================================================
// Module      : avl_mm_dot_accel_if
// Description : Avalon-MM style slave bus bundle for the dot-product
//               accelerator.
//               _CS          chip select
//               _WRITE_DATA  write strobe
//               _READ_DATA   read strobe
//               _ADDR[2:0]   register address
//               _DATA_IN     write data
//               DATA_OUT_    registered read data
//               VALID_       one-cycle read-data-valid pulse
//               IRQ_         done interrupt (level)
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface avl_mm_dot_accel_if;
    logic        _CS;
    logic        _WRITE_DATA;
    logic        _READ_DATA;
    logic [2:0]  _ADDR;
    logic [31:0] _DATA_IN;
    logic [31:0] DATA_OUT_;
    logic        VALID_;
    logic        IRQ_;

    modport slave (
        input  _CS, _WRITE_DATA, _READ_DATA, _ADDR, _DATA_IN,
        output DATA_OUT_, VALID_, IRQ_
    );

    modport master (
        output _CS, _WRITE_DATA, _READ_DATA, _ADDR, _DATA_IN,
        input  DATA_OUT_, VALID_, IRQ_
    );
endinterface

`default_nettype wire

// File: rtl/avl_mm_dot_accel_lane_mac.sv
// ============================================================================
// Module      : dot_lane_mac
// Description : LANES parallel BITS x BITS multipliers feeding an adder tree,
//               registered output (one-cycle latency, updates when i_en).
//               Ports: _CLK, _RST (async, active-high), i_en, i_a, i_b (packed
//               32-bit words), o_sum (SUM_W-bit lane sum).
//               Optional feature macro: AVL_DOT_SIGNED_EN (signed elements).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dot_lane_mac
    import dot_accel_pkg::*;
#(
    parameter int BITS  = 8,
    parameter int LANES = 32 / BITS,
    parameter int SUM_W = 2 * BITS + $clog2(LANES)
) (
    input  wire logic             _CLK,
    input  wire logic             _RST,
    input  wire logic             i_en,
    input  wire logic [31:0]      i_a,
    input  wire logic [31:0]      i_b,
    output logic      [SUM_W-1:0] o_sum
);

    logic [SUM_W-1:0] w_tree;
    logic [SUM_W-1:0] sum_d;
    logic [SUM_W-1:0] sum_q;

    // Operands are widened to SUM_W before multiplying so the same modular
    // arithmetic covers both the signed and the unsigned flavour.
    always_comb begin
        logic [SUM_W-1:0] ea;
        logic [SUM_W-1:0] eb;
        ea     = '0;
        eb     = '0;
        w_tree = '0;
        for (int l = 0; l < LANES; l++) begin
            ea = {{(SUM_W-BITS){SIGNED_EN & i_a[l*BITS+BITS-1]}}, i_a[l*BITS +: BITS]};
            eb = {{(SUM_W-BITS){SIGNED_EN & i_b[l*BITS+BITS-1]}}, i_b[l*BITS +: BITS]};
            w_tree = w_tree + ea * eb;
        end
        sum_d = i_en ? w_tree : sum_q;
    end

    always_ff @(posedge _CLK or posedge _RST) begin
        if (_RST) sum_q <= '0;
        else      sum_q <= sum_d;
    end

    assign o_sum = sum_q;

endmodule

`default_nettype wire

// File: rtl/avl_mm_dot_accel.sv
// ============================================================================
// Module      : avl_mm_dot_accel
// Description : Avalon-MM slave dot-product accelerator. Host fills the A and
//               B vector buffers, writes LEN and pulses START; one word per
//               cycle is streamed through the lane MAC and accumulated.
//               Ports: _CLK, _RST (async, active-high), bus (slave modport:
//               _CS, _WRITE_DATA, _READ_DATA, _ADDR, _DATA_IN, DATA_OUT_,
//               VALID_, IRQ_).
//               Optional feature macro: AVL_DOT_SIGNED_EN (signed elements,
//               RESULT sign-extended; otherwise unsigned, zero-extended).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module avl_mm_dot_accel
    import dot_accel_pkg::*;
#(
    parameter int BITS  = 8,
    parameter int LANES = 32 / BITS,
    parameter int DEPTH = 4,                      // power of 2, >= 2
    parameter int ACC_W = 2 * BITS + $clog2(LANES * DEPTH)
) (
    input  wire logic          _CLK,
    input  wire logic          _RST,
    avl_mm_dot_accel_if.slave  bus
);

    localparam int SUM_W = 2 * BITS + $clog2(LANES);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int LEN_W = $clog2(DEPTH + 1);

    // Vector buffers (not reset)
    logic [31:0] a_buf [DEPTH];
    logic [31:0] b_buf [DEPTH];

    logic [1:0]       state_q,    state_d;
    logic [PTR_W-1:0] wptr_a_q,   wptr_a_d;
    logic [PTR_W-1:0] wptr_b_q,   wptr_b_d;
    logic [PTR_W-1:0] rd_idx_q,   rd_idx_d;
    logic [LEN_W-1:0] cnt_q,      cnt_d;
    logic [LEN_W-1:0] len_q,      len_d;
    logic [ACC_W-1:0] acc_q,      acc_d;
    logic [31:0]      result_q,   result_d;
    logic             done_q,     done_d;
    logic             mac_vld_q,  mac_vld_d;
    logic [31:0]      data_out_q, data_out_d;
    logic             valid_q,    valid_d;

    logic             w_wr, w_rd, w_busy, w_wr_ok;
    logic             w_start, w_clear, w_a_we, w_b_we, w_len_we;
    logic             w_mac_en;
    logic [SUM_W-1:0] w_mac_sum;
    logic [ACC_W-1:0] w_mac_ext;
    logic [ACC_W-1:0] w_final;
    logic [31:0]      w_result_ext;
    logic [31:0]      w_rd_word;

    // Bus decode: a write wins over a simultaneous read
    always_comb begin
        w_wr     = bus._CS & bus._WRITE_DATA;
        w_rd     = bus._CS & bus._READ_DATA & ~bus._WRITE_DATA;
        w_busy   = (state_q == c_st_run) || (state_q == c_st_drain);
        w_wr_ok  = w_wr & ~w_busy;
        w_start  = w_wr_ok & (bus._ADDR == c_addr_ctrl) & bus._DATA_IN[c_ctrl_start_bit];
        w_clear  = w_wr_ok & (bus._ADDR == c_addr_ctrl) & bus._DATA_IN[c_ctrl_clear_bit];
        w_a_we   = w_wr_ok & (bus._ADDR == c_addr_a_push);
        w_b_we   = w_wr_ok & (bus._ADDR == c_addr_b_push);
        w_len_we = w_wr_ok & (bus._ADDR == c_addr_len);
        w_mac_en = (state_q == c_st_run);
    end

    dot_lane_mac #(
        .BITS  (BITS),
        .LANES (LANES),
        .SUM_W (SUM_W)
    ) u_mac (
        ._CLK  (_CLK),
        ._RST  (_RST),
        .i_en  (w_mac_en),
        .i_a   (a_buf[rd_idx_q]),
        .i_b   (b_buf[rd_idx_q]),
        .o_sum (w_mac_sum)
    );

    // Width extension of the lane sum and of the final result
    always_comb begin
        w_mac_ext                  = {ACC_W{SIGNED_EN & w_mac_sum[SUM_W-1]}};
        w_mac_ext[SUM_W-1:0]       = w_mac_sum;
        w_final                    = acc_q + w_mac_ext;
        w_result_ext               = {32{SIGNED_EN & w_final[ACC_W-1]}};
        w_result_ext[ACC_W-1:0]    = w_final;
    end

    // Control path
    always_comb begin
        state_d   = state_q;
        wptr_a_d  = wptr_a_q;
        wptr_b_d  = wptr_b_q;
        rd_idx_d  = rd_idx_q;
        cnt_d     = cnt_q;
        len_d     = len_q;
        acc_d     = acc_q;
        result_d  = result_q;
        done_d    = done_q;
        mac_vld_d = mac_vld_q;

        // Pointers wrap naturally because DEPTH is a power of two
        if (w_a_we)   wptr_a_d = wptr_a_q + PTR_W'(1);
        if (w_b_we)   wptr_b_d = wptr_b_q + PTR_W'(1);
        if (w_len_we) len_d    = LEN_W'(clamp_len(bus._DATA_IN, 32'(DEPTH)));
        if (w_clear) begin
            wptr_a_d = '0;
            wptr_b_d = '0;
            done_d   = 1'b0;
        end

        case (state_q)
            c_st_run: begin
                // The MAC output lags issue by one cycle; mac_vld_q marks
                // whether it holds a real product yet.
                if (mac_vld_q) acc_d = acc_q + w_mac_ext;
                mac_vld_d = 1'b1;
                rd_idx_d  = rd_idx_q + PTR_W'(1);
                cnt_d     = cnt_q + LEN_W'(1);
                if (cnt_q == len_q - LEN_W'(1)) state_d = c_st_drain;
            end
            c_st_drain: begin
                result_d  = w_result_ext;
                done_d    = 1'b1;
                mac_vld_d = 1'b0;
                state_d   = c_st_done;
            end
            default: begin  // IDLE and DONE both accept a new START
                state_d = c_st_idle;
                if (w_start) begin
                    state_d   = c_st_run;
                    acc_d     = '0;
                    rd_idx_d  = '0;
                    cnt_d     = '0;
                    done_d    = 1'b0;
                    mac_vld_d = 1'b0;
                end
            end
        endcase
    end

    // Read path: one-cycle registered response
    always_comb begin
        w_rd_word = '0;
        case (bus._ADDR)
            c_addr_ctrl: begin
                w_rd_word[c_stat_busy_bit] = w_busy;
                w_rd_word[c_stat_done_bit] = done_q;
            end
            c_addr_len:    w_rd_word = 32'(len_q);
            c_addr_result: w_rd_word = result_q;
            default:       w_rd_word = '0;
        endcase
        data_out_d = w_rd ? w_rd_word : data_out_q;
        valid_d    = w_rd;
    end

    always_ff @(posedge _CLK or posedge _RST) begin
        if (_RST) begin
            state_q    <= c_st_idle;
            wptr_a_q   <= '0;
            wptr_b_q   <= '0;
            rd_idx_q   <= '0;
            cnt_q      <= '0;
            len_q      <= LEN_W'(DEPTH);
            acc_q      <= '0;
            result_q   <= '0;
            done_q     <= 1'b0;
            mac_vld_q  <= 1'b0;
            data_out_q <= '0;
            valid_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            wptr_a_q   <= wptr_a_d;
            wptr_b_q   <= wptr_b_d;
            rd_idx_q   <= rd_idx_d;
            cnt_q      <= cnt_d;
            len_q      <= len_d;
            acc_q      <= acc_d;
            result_q   <= result_d;
            done_q     <= done_d;
            mac_vld_q  <= mac_vld_d;
            data_out_q <= data_out_d;
            valid_q    <= valid_d;
        end
    end

    always_ff @(posedge _CLK) begin
        if (w_a_we) a_buf[wptr_a_q] <= bus._DATA_IN;
        if (w_b_we) b_buf[wptr_b_q] <= bus._DATA_IN;
    end

    assign bus.DATA_OUT_ = data_out_q;
    assign bus.VALID_    = valid_q;
    assign bus.IRQ_      = done_q;

endmodule

`default_nettype wire
